// File: rtl/rxrbcnt_pkg.sv
// Shared definitions for the RX byte-count read sequencer: state encoding,
// descriptor field offsets and the last-beat keep helper.
package rxrbcnt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_POP    = 2'd1,
      ST_LOAD   = 2'd2,
      ST_STREAM = 2'd3
   } state_t;

   localparam int LEN_LSB = 0;
   localparam int ERR_BIT = 16;

   // Byte lanes valid on the final beat; rem==0 means a full 8-byte beat.
   function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
      logic [7:0] keep;
      if (rem == 3'd0) keep = 8'hFF;
      else             keep = 8'hFF >> (4'd8 - {1'b0, rem});
      return keep;
   endfunction

endpackage

// File: rtl/rxrbcnt_skid2.sv
// Two-entry in-order output buffer. Entry 0 is the head and drives the
// stream outputs; entries are zeroed when vacated so an empty buffer
// presents all-zero payload.
module rxrbcnt_skid2 #(
   parameter int DW = 74
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic [DW-1:0] i_din,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_dout,
   output logic [1:0]    o_occ,
   output logic          o_pop
);

   logic [DW-1:0] r_ent0;
   logic [DW-1:0] r_ent1;
   logic [1:0]    r_occ;
   logic          w_pop;

   assign w_pop   = (r_occ != 2'd0) & i_ready;
   assign o_valid = (r_occ != 2'd0);
   assign o_dout  = r_ent0;
   assign o_occ   = r_occ;
   assign o_pop   = w_pop;

   // Push/pop bookkeeping; the head always holds the oldest beat.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ent0 <= '0;
         r_ent1 <= '0;
         r_occ  <= 2'd0;
      end else begin
         unique case ({i_push, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_ent0 <= i_din;
               else               r_ent1 <= i_din;
               if (r_occ != 2'd2) r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_ent0 <= r_ent1;
               r_ent1 <= '0;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_ent0 <= i_din;
               end else begin
                  r_ent0 <= r_ent1;
                  r_ent1 <= i_din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rxrbcnt_rd_ctrl.sv
// Read-side sequencer for the RX byte-count FIFO and RX data FIFO.
// Pops one descriptor per packet, reads the packet's beats from the data
// FIFO and presents them as an AXI4-Stream master.
// Optional build macro: RXRBCNT_DROP_ERR_EN -- errored packets are drained
// from the data FIFO but not delivered, and counted as drops.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for a descriptor in the byte-count FIFO
//  ST_POP    | cnt_rden asserted for one cycle
//  ST_LOAD   | descriptor valid on cnt_dataout; validate and latch it
//  ST_STREAM | issuing data FIFO reads until beats_left reaches zero
module rxrbcnt_rd_ctrl
   import rxrbcnt_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int LEN_W     = 16,
   parameter int MAX_BYTES = 9600
) (
   input  logic             rdclk,
   input  logic             reset,
   input  logic             cnt_rdempty,
   output logic             cnt_rden,
   input  logic [63:0]      cnt_dataout,
   input  logic             dat_rdempty,
   output logic             dat_rden,
   input  logic [WIDTH-1:0] dat_dataout,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [WIDTH-1:0] m_axis_tdata,
   output logic [7:0]       m_axis_tkeep,
   output logic             m_axis_tlast,
   output logic             m_axis_tuser,
   output logic [31:0]      pkt_cnt,
   output logic [15:0]      drop_cnt,
   output logic             busy
);

`ifdef RXRBCNT_DROP_ERR_EN
   localparam bit DROP_ERR = 1'b1;
`else
   localparam bit DROP_ERR = 1'b0;
`endif

   localparam int BW = WIDTH + 10;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LEN_W-1:0] r_beats_left;
   logic             r_err;
   logic [2:0]       r_rem;
   logic             r_inflight;
   logic             r_tag_last;
   logic [7:0]       r_tag_keep;
   logic             r_tag_user;
   logic             r_tag_drop;
   logic [31:0]      r_pkt_cnt;
   logic [15:0]      r_drop_cnt;

   logic             w_cnt_rden;
   logic             w_dat_rden;
   logic [LEN_W-1:0] w_len;
   logic             w_err;
   logic             w_len_bad;
   logic             w_err_drop;
   logic [LEN_W-1:0] w_beats;
   logic             w_last_beat;
   logic             w_room;
   logic             w_push;
   logic [BW-1:0]    w_push_din;
   logic [BW-1:0]    w_head;
   logic             w_head_valid;
   logic [1:0]       w_occ;
   logic             w_pop;
   logic             w_unused_rsvd;

   assign w_len         = cnt_dataout[LEN_LSB +: LEN_W];
   assign w_err         = cnt_dataout[ERR_BIT];
   assign w_unused_rsvd = ^cnt_dataout[63:ERR_BIT+1];
   assign w_len_bad     = (w_len == '0) || (w_len > LEN_W'(MAX_BYTES));
   assign w_err_drop    = DROP_ERR & w_err & ~w_len_bad;
   assign w_beats       = (w_len + LEN_W'(7)) >> 3;
   assign w_last_beat   = (r_beats_left == LEN_W'(1));

   // Reads in flight plus buffered beats must fit the two-entry buffer.
   assign w_room = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

   // Next-state and FIFO read enables.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_rden  = 1'b0;
      w_dat_rden  = 1'b0;
      case (r_state)
         ST_IDLE:   if (!cnt_rdempty) w_state_nxt = ST_POP;
         ST_POP: begin
            w_cnt_rden  = 1'b1;
            w_state_nxt = ST_LOAD;
         end
         ST_LOAD:   w_state_nxt = w_len_bad ? ST_IDLE : ST_STREAM;
         ST_STREAM: begin
            w_dat_rden = (r_beats_left != '0) && !dat_rdempty && w_room;
            if (w_dat_rden && w_last_beat) w_state_nxt = ST_IDLE;
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge rdclk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Descriptor latch, beat countdown and per-read tag.
   always_ff @(posedge rdclk) begin
      if (reset) begin
         r_beats_left <= '0;
         r_err        <= 1'b0;
         r_rem        <= 3'd0;
         r_inflight   <= 1'b0;
         r_tag_last   <= 1'b0;
         r_tag_keep   <= 8'h00;
         r_tag_user   <= 1'b0;
         r_tag_drop   <= 1'b0;
      end else begin
         r_inflight <= w_dat_rden;
         if (r_state == ST_LOAD && !w_len_bad) begin
            r_beats_left <= w_beats;
            r_err        <= w_err;
            r_rem        <= w_len[2:0];
         end else if (w_dat_rden) begin
            r_beats_left <= r_beats_left - LEN_W'(1);
         end
         if (w_dat_rden) begin
            r_tag_last <= w_last_beat;
            r_tag_keep <= w_last_beat ? keep_from_rem(r_rem) : 8'hFF;
            r_tag_user <= w_last_beat & r_err;
            r_tag_drop <= DROP_ERR & r_err;
         end
      end
   end

   // Delivered-packet and dropped-descriptor counters.
   always_ff @(posedge rdclk) begin
      if (reset) begin
         r_pkt_cnt  <= 32'd0;
         r_drop_cnt <= 16'd0;
      end else begin
         if (w_pop && m_axis_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
         if (r_state == ST_LOAD && (w_len_bad || w_err_drop) && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign w_push     = r_inflight & ~r_tag_drop;
   assign w_push_din = {dat_dataout, r_tag_keep, r_tag_last, r_tag_user};

   rxrbcnt_skid2 #(.DW(BW)) u_skid (
      .i_clk   (rdclk),
      .i_reset (reset),
      .i_push  (w_push),
      .i_din   (w_push_din),
      .i_ready (m_axis_tready),
      .o_valid (w_head_valid),
      .o_dout  (w_head),
      .o_occ   (w_occ),
      .o_pop   (w_pop)
   );

   assign cnt_rden      = w_cnt_rden;
   assign dat_rden      = w_dat_rden;
   assign m_axis_tvalid = w_head_valid;
   assign m_axis_tdata  = w_head[BW-1:10];
   assign m_axis_tkeep  = w_head[9:2];
   assign m_axis_tlast  = w_head[1];
   assign m_axis_tuser  = DROP_ERR ? 1'b0 : w_head[0];
   assign pkt_cnt       = r_pkt_cnt;
   assign drop_cnt      = r_drop_cnt;
   assign busy          = (r_state != ST_IDLE) || (w_occ != 2'd0);

endmodule

// File: tb/tb_rxrbcnt_rd_ctrl.sv
// Bench for rxrbcnt_rd_ctrl: behavioural FIFO models feed the DUT, and the
// expected beat stream is derived from each packet's byte length.
`timescale 1ns/1ps
module tb_rxrbcnt_rd_ctrl;

`ifdef RXRBCNT_DROP_ERR_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif
   localparam int LIMIT = 20000;

   logic        rdclk = 1'b0;
   logic        reset = 1'b1;
   logic        cnt_rdempty = 1'b1;
   logic        cnt_rden;
   logic [63:0] cnt_dataout = '0;
   logic        dat_rdempty = 1'b1;
   logic        dat_rden;
   logic [63:0] dat_dataout = '0;
   logic        tvalid;
   logic        tready = 1'b0;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tuser;
   logic [31:0] pkt_cnt;
   logic [15:0] drop_cnt;
   logic        busy;

   always #5 rdclk = ~rdclk;

   rxrbcnt_rd_ctrl dut (
      .rdclk(rdclk), .reset(reset),
      .cnt_rdempty(cnt_rdempty), .cnt_rden(cnt_rden), .cnt_dataout(cnt_dataout),
      .dat_rdempty(dat_rdempty), .dat_rden(dat_rden), .dat_dataout(dat_dataout),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
      .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
      .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .busy(busy)
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   logic [63:0] cnt_q[$];
   logic [63:0] dat_q[$];
   beat_t       exp_q[$];

   int n_cmp = 0, n_err = 0;
   int exp_pkt = 0, exp_drop = 0;
   int cyc = 0, hs_count = 0, first_hs = 0, last_hs = 0, rden_count = 0;
   int rdy_mode = 0, stall_pct = 0;
   bit pend_cnt = 0, pend_dat = 0, prev_stall = 0, prev_cnt_rden = 0;
   logic [63:0] prev_data;
   logic [7:0]  prev_keep;
   logic        prev_last, prev_user;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Queue one descriptor plus its data words and the expected stream.
   task automatic add_pkt(input int len, input bit err);
      logic [63:0] desc;
      logic [63:0] w;
      beat_t       b;
      int          nb, bytes;
      desc = {$urandom(), $urandom()};
      desc[15:0] = 16'(len);
      desc[16] = err;
      cnt_q.push_back(desc);
      if (len == 0 || len > 9600) begin
         exp_drop++;
         return;
      end
      nb = (len + 7) / 8;
      for (int i = 0; i < nb; i++) begin
         w = {$urandom(), $urandom()};
         dat_q.push_back(w);
         bytes  = len - 8 * i;
         b.data = w;
         b.last = (i == nb - 1);
         b.keep = (bytes >= 8) ? 8'hFF : 8'((1 << bytes) - 1);
         b.user = err && b.last;
         if (!(DROP && err)) exp_q.push_back(b);
      end
      if (DROP && err) exp_drop++;
      else             exp_pkt++;
   endtask

   // One cycle: update FIFO models, drive inputs, sample and check outputs.
   task automatic step();
      beat_t b;
      @(negedge rdclk);
      cyc++;
      if (pend_cnt && cnt_q.size() != 0) cnt_dataout = cnt_q.pop_front();
      if (pend_dat && dat_q.size() != 0) dat_dataout = dat_q.pop_front();
      cnt_rdempty = (cnt_q.size() == 0);
      dat_rdempty = (dat_q.size() == 0) || ($urandom_range(99) < stall_pct);
      case (rdy_mode)
         0:       tready = 1'b1;
         1:       tready = ~tready;
         default: tready = 1'($urandom_range(1));
      endcase
      #1;
      if (prev_stall) begin
         chk("hold_valid", {63'd0, tvalid}, 64'd1);
         chk("hold_data", tdata, prev_data);
         chk("hold_keep", {56'd0, tkeep}, {56'd0, prev_keep});
         chk("hold_last", {63'd0, tlast}, {63'd0, prev_last});
         chk("hold_user", {63'd0, tuser}, {63'd0, prev_user});
      end
      if (cnt_rden) begin
         chk("cnt_rden_while_empty", {63'd0, cnt_rdempty}, 64'd0);
         chk("cnt_rden_pulse", {63'd0, prev_cnt_rden}, 64'd0);
      end
      if (dat_rden) begin
         chk("dat_rden_while_empty", {63'd0, dat_rdempty}, 64'd0);
         rden_count++;
      end
      if (tvalid && tready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {63'd0, tvalid}, 64'd0);
         end else begin
            b = exp_q.pop_front();
            chk("beat_data", tdata, b.data);
            chk("beat_keep", {56'd0, tkeep}, {56'd0, b.keep});
            chk("beat_last", {63'd0, tlast}, {63'd0, b.last});
            chk("beat_user", {63'd0, tuser}, {63'd0, b.user});
         end
         if (hs_count == 0) first_hs = cyc;
         last_hs = cyc;
         hs_count++;
      end
      prev_stall    = tvalid && !tready;
      prev_data     = tdata;
      prev_keep     = tkeep;
      prev_last     = tlast;
      prev_user     = tuser;
      prev_cnt_rden = cnt_rden;
      pend_cnt      = cnt_rden && !cnt_rdempty;
      pend_dat      = dat_rden && !dat_rdempty;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || cnt_q.size() != 0 || dat_q.size() != 0 ||
              busy || pend_dat || pend_cnt) && n < LIMIT) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, {63'd0, (n < LIMIT)}, 64'd1);
      repeat (4) step();
      chk({tag, "_pkt_cnt"}, {32'd0, pkt_cnt}, 64'(exp_pkt));
      chk({tag, "_drop_cnt"}, {48'd0, drop_cnt}, 64'(exp_drop));
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge rdclk);
      reset = 1'b1;
      cnt_q.delete(); dat_q.delete(); exp_q.delete();
      pend_cnt = 0; pend_dat = 0; prev_stall = 0; prev_cnt_rden = 0;
      cnt_dataout = '0; dat_dataout = '0;
      cnt_rdempty = 1'b1; dat_rdempty = 1'b1;
      exp_pkt = 0; exp_drop = 0;
      @(negedge rdclk);
      reset = 1'b0;
      #1;
      chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
      chk("rst_tdata", tdata, 64'd0);
      chk("rst_tkeep", {56'd0, tkeep}, 64'd0);
      chk("rst_tlast", {63'd0, tlast}, 64'd0);
      chk("rst_tuser", {63'd0, tuser}, 64'd0);
      chk("rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
      chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_cnt_rden", {63'd0, cnt_rden}, 64'd0);
      chk("rst_dat_rden", {63'd0, dat_rden}, 64'd0);
   endtask

   initial begin
      int len, n;
      do_reset();

      // 64 bytes, tready high, no stalls: 8 back-to-back beats
      rdy_mode = 0; stall_pct = 0; hs_count = 0;
      add_pkt(64, 0);
      drain("len64");
      chk("len64_beats", 64'(hs_count), 64'd8);
      chk("len64_consecutive", 64'(last_hs - first_hs), 64'd7);

      // partial last beats
      hs_count = 0;
      add_pkt(61, 0);
      add_pkt(1, 0);
      drain("len61_1");
      chk("len61_1_beats", 64'(hs_count), 64'd9);

      // illegal lengths dropped, following packet delivered
      hs_count = 0; rden_count = 0;
      add_pkt(0, 0);
      add_pkt(9601, 0);
      add_pkt(8, 0);
      drain("drop");
      chk("drop_beats", 64'(hs_count), 64'd1);
      chk("drop_rdens", 64'(rden_count), 64'd1);

      // back-pressure toggling and data FIFO empty pulses
      rdy_mode = 1; stall_pct = 30; hs_count = 0;
      add_pkt(128, 0);
      drain("len128");
      chk("len128_beats", 64'(hs_count), 64'd16);

      // errored packet
      rdy_mode = 0; stall_pct = 0; hs_count = 0; rden_count = 0;
      add_pkt(16, 1);
      drain("err16");
      chk("err16_rdens", 64'(rden_count), 64'd2);
      chk("err16_beats", 64'(hs_count), DROP ? 64'd0 : 64'd2);

      // randomized mix
      rdy_mode = 2; stall_pct = 25;
      for (int i = 0; i < 24; i++) begin
         n = $urandom_range(9);
         if (n == 0)      len = 0;
         else if (n == 1) len = 9601 + $urandom_range(200);
         else             len = $urandom_range(1, 200);
         add_pkt(len, ($urandom_range(3) == 0));
      end
      add_pkt(9600, 0);
      add_pkt(9599, 1);
      drain("random");

      // reset during beat 3 of a 10-beat packet
      do_reset();
      rdy_mode = 0; stall_pct = 0; hs_count = 0;
      add_pkt(80, 0);
      n = 0;
      while (hs_count < 2 && n < 200) begin
         step();
         n++;
      end
      chk("midrst_reach_beat3", {63'd0, (n < 200)}, 64'd1);
      do_reset();
      add_pkt(24, 0);
      drain("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
